// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU, loader and memory-port signals shared by the arbiter and its environment.
// slave is the arbiter side; master is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_ack;
    logic [DATA_W-1:0] ld_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    logic [1:0]        grant;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_ack, ld_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata,
        output grant, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_ack, ld_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata,
        input  grant, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a CPU and a program loader.
// Each granted access walks IDLE -> ACCESS -> WAIT -> DONE; all outputs are registered.
module mem_port_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

    state_e state;
    logic   last_ld;
    logic   lat_we;

    logic              win_ld;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Loader wins when alone, or on a tie when the CPU held the port last.
    always_comb begin
        win_ld    = bus.ld_req && (!bus.cpu_req || !last_ld);
        sel_we    = win_ld ? bus.ld_we    : bus.cpu_we;
        sel_addr  = win_ld ? bus.ld_addr  : bus.cpu_addr;
        sel_wdata = win_ld ? bus.ld_wdata : bus.cpu_wdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= StIdle;
            last_ld       <= 1'b1;
            lat_we        <= 1'b0;
            bus.grant     <= 2'b00;
            bus.busy      <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.ld_ack    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.cpu_rdata <= '0;
            bus.ld_rdata  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.cpu_req || bus.ld_req) begin
                        state         <= StAccess;
                        last_ld       <= win_ld;
                        lat_we        <= sel_we;
                        bus.grant     <= win_ld ? 2'b10 : 2'b01;
                        bus.busy      <= 1'b1;
                        bus.mem_addr  <= sel_addr;
                        bus.mem_wdata <= sel_wdata;
                        bus.mem_we    <= sel_we;
                        bus.mem_re    <= !sel_we;
                    end
                end
                StAccess: begin
                    state      <= StWait;
                    bus.mem_we <= 1'b0;
                    bus.mem_re <= 1'b0;
                end
                StWait: begin
                    state       <= StDone;
                    bus.cpu_ack <= bus.grant[0];
                    bus.ld_ack  <= bus.grant[1];
                    // Read data arrives the cycle after the strobe, i.e. now.
                    if (!lat_we) begin
                        if (bus.grant[1]) bus.ld_rdata  <= bus.mem_rdata;
                        else              bus.cpu_rdata <= bus.mem_rdata;
                    end
                end
                StDone: begin
                    state       <= StIdle;
                    bus.grant   <= 2'b00;
                    bus.busy    <= 1'b0;
                    bus.cpu_ack <= 1'b0;
                    bus.ld_ack  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, tie/abort sequences
// and randomized transactions against a behavioural memory/round-robin model.
module tb_mem_port_arbiter;

    logic clock;
    logic reset_n;

    mem_port_arbiter_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    mem_port_arbiter #(.DATA_W(16), .ADDR_W(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory stand-in: read data appears one cycle after the mem_re cycle.
    logic [15:0] mem [256];
    always @(posedge clock) begin
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    int checks;
    int errors;

    typedef struct packed {
        logic        c_req;
        logic        c_we;
        logic [7:0]  c_addr;
        logic [15:0] c_wdata;
        logic        l_req;
        logic        l_we;
        logic [7:0]  l_addr;
        logic [15:0] l_wdata;
        logic [1:0]  exp_grant;
        logic [15:0] exp_crd;
        logic [15:0] exp_lrd;
    } vec_t;

    vec_t vecs [8];

    logic [15:0] ref_mem [256];
    logic [15:0] ref_rd [2];
    int          last_winner;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".grant"},     32'(bus.grant),     32'h0);
        chk({tag, ".busy"},      32'(bus.busy),      32'h0);
        chk({tag, ".cpu_ack"},   32'(bus.cpu_ack),   32'h0);
        chk({tag, ".ld_ack"},    32'(bus.ld_ack),    32'h0);
        chk({tag, ".mem_we"},    32'(bus.mem_we),    32'h0);
        chk({tag, ".mem_re"},    32'(bus.mem_re),    32'h0);
        chk({tag, ".mem_addr"},  32'(bus.mem_addr),  32'h0);
        chk({tag, ".mem_wdata"}, 32'(bus.mem_wdata), 32'h0);
        chk({tag, ".cpu_rdata"}, 32'(bus.cpu_rdata), 32'h0);
        chk({tag, ".ld_rdata"},  32'(bus.ld_rdata),  32'h0);
    endtask

    task automatic do_reset(input string tag);
        bus.cpu_req = 1'b0;
        bus.ld_req  = 1'b0;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 check_reset_state(tag);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // One full transaction; requests drop right after being sampled.
    task automatic run_vec(input vec_t v, input string tag);
        logic        w_we;
        logic [7:0]  w_addr;
        logic [15:0] w_wdata;
        w_we    = v.exp_grant[1] ? v.l_we    : v.c_we;
        w_addr  = v.exp_grant[1] ? v.l_addr  : v.c_addr;
        w_wdata = v.exp_grant[1] ? v.l_wdata : v.c_wdata;

        bus.cpu_req   = v.c_req;
        bus.cpu_we    = v.c_we;
        bus.cpu_addr  = v.c_addr;
        bus.cpu_wdata = v.c_wdata;
        bus.ld_req    = v.l_req;
        bus.ld_we     = v.l_we;
        bus.ld_addr   = v.l_addr;
        bus.ld_wdata  = v.l_wdata;

        @(posedge clock); #1;
        chk({tag, ".acc_grant"}, 32'(bus.grant),     32'(v.exp_grant));
        chk({tag, ".acc_busy"},  32'(bus.busy),      32'h1);
        chk({tag, ".acc_we"},    32'(bus.mem_we),    32'(w_we));
        chk({tag, ".acc_re"},    32'(bus.mem_re),    32'(!w_we));
        chk({tag, ".acc_addr"},  32'(bus.mem_addr),  32'(w_addr));
        chk({tag, ".acc_wdata"}, 32'(bus.mem_wdata), 32'(w_wdata));
        bus.cpu_req = 1'b0;
        bus.ld_req  = 1'b0;

        @(posedge clock); #1;
        chk({tag, ".wait_strobe"}, 32'({bus.mem_we, bus.mem_re}), 32'h0);
        chk({tag, ".wait_acks"},   32'({bus.ld_ack, bus.cpu_ack}), 32'h0);

        @(posedge clock); #1;
        chk({tag, ".done_acks"},  32'({bus.ld_ack, bus.cpu_ack}), 32'(v.exp_grant));
        chk({tag, ".done_grant"}, 32'(bus.grant),     32'(v.exp_grant));
        chk({tag, ".cpu_rdata"},  32'(bus.cpu_rdata), 32'(v.exp_crd));
        chk({tag, ".ld_rdata"},   32'(bus.ld_rdata),  32'(v.exp_lrd));

        @(posedge clock); #1;
        chk({tag, ".idle_acks"},  32'({bus.ld_ack, bus.cpu_ack}), 32'h0);
        chk({tag, ".idle_busy"},  32'(bus.busy),  32'h0);
        chk({tag, ".idle_grant"}, 32'(bus.grant), 32'h0);
    endtask

    initial begin
        int          order [$];
        int          both_ack;
        logic [15:0] v16;
        vec_t        rv;
        int          winner;
        logic [7:0]  a;

        checks = 0;
        errors = 0;
        reset_n = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ld_req  = 1'b0; bus.ld_we  = 1'b0; bus.ld_addr  = '0; bus.ld_wdata  = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'hBEEF;
        mem[8'h21] = 16'hC0DE;
        mem[8'h22] = 16'h1357;
        mem[8'h30] = 16'h4242;

        //          creq cwe caddr  cwdata    lreq lwe laddr  lwdata    grant  crd       lrd
        vecs[0] = '{1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b01, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b1, 1'b1, 8'hFF, 16'h1234, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b01, 16'hBEEF, 16'h0000};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h05, 16'h00AA, 2'b10, 16'hBEEF, 16'h0000};
        vecs[3] = '{1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b01, 16'h00AA, 16'h0000};
        vecs[4] = '{1'b1, 1'b0, 8'h30, 16'h0000, 1'b1, 1'b0, 8'h21, 16'h0000, 2'b10, 16'h00AA, 16'hC0DE};
        vecs[5] = '{1'b1, 1'b0, 8'h30, 16'h0000, 1'b1, 1'b1, 8'h40, 16'h7777, 2'b01, 16'h4242, 16'hC0DE};
        vecs[6] = '{1'b1, 1'b1, 8'h41, 16'h1111, 1'b1, 1'b0, 8'hFF, 16'h0000, 2'b10, 16'h4242, 16'h1234};
        vecs[7] = '{1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b01, 16'h1234, 16'h1234};

        do_reset("rst0");
        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Tie with both requests held; each side drops on its ack and re-raises next cycle.
        do_reset("rst1");
        bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10;
        bus.ld_we  = 1'b0; bus.ld_addr  = 8'h21;
        bus.cpu_req = 1'b1;
        bus.ld_req  = 1'b1;
        both_ack = 0;
        for (int cyc = 0; cyc < 60 && order.size() < 4; cyc++) begin
            @(posedge clock); #1;
            if (bus.cpu_ack && bus.ld_ack) both_ack++;
            if (!bus.cpu_req && !bus.cpu_ack) bus.cpu_req = 1'b1;
            if (!bus.ld_req && !bus.ld_ack)   bus.ld_req  = 1'b1;
            if (bus.cpu_ack) begin order.push_back(0); bus.cpu_req = 1'b0; end
            if (bus.ld_ack)  begin order.push_back(1); bus.ld_req  = 1'b0; end
        end
        bus.cpu_req = 1'b0;
        bus.ld_req  = 1'b0;
        chk("tie.count", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("tie.order%0d", i), (i < order.size()) ? 32'(order[i]) : 32'd9,
                32'(i % 2));
        chk("tie.both_acks", 32'(both_ack), 32'd0);
        repeat (4) @(posedge clock);
        #1 chk("tie.cpu_rdata", 32'(bus.cpu_rdata), 32'hBEEF);

        // Reset asserted mid-ACCESS of a write must kill the strobe without a clock edge.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h60; bus.cpu_wdata = 16'h5555;
        @(posedge clock); #1;
        chk("abort.mem_we_before", 32'(bus.mem_we), 32'h1);
        bus.cpu_req = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_reset_state("abort");
        repeat (2) begin
            @(posedge clock); #1;
            chk("abort.no_ack", 32'({bus.ld_ack, bus.cpu_ack}), 32'h0);
        end
        chk("abort.no_write", 32'(mem[8'h60]), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        run_vec('{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h22, 16'h0000,
                  2'b10, 16'h0000, 16'h1357}, "post_abort");

        // Randomized transactions against a behavioural model.
        do_reset("rst2");
        for (int i = 0; i < 256; i++) begin
            v16 = 16'($urandom);
            mem[i]     = v16;
            ref_mem[i] = v16;
        end
        ref_rd[0] = 16'h0000;
        ref_rd[1] = 16'h0000;
        last_winner = 1;
        for (int n = 0; n < 60; n++) begin
            rv.c_req   = 1'($urandom);
            rv.l_req   = 1'($urandom);
            if (!rv.c_req && !rv.l_req) rv.c_req = 1'b1;
            rv.c_we    = 1'($urandom);
            rv.l_we    = 1'($urandom);
            rv.c_addr  = 8'($urandom);
            rv.l_addr  = (n % 4 == 0) ? rv.c_addr : 8'($urandom);
            rv.c_wdata = 16'($urandom);
            rv.l_wdata = 16'($urandom);
            if (rv.c_req && rv.l_req) winner = 1 - last_winner;
            else                      winner = rv.l_req ? 1 : 0;
            last_winner = winner;
            a = (winner == 1) ? rv.l_addr : rv.c_addr;
            if ((winner == 1) ? rv.l_we : rv.c_we)
                ref_mem[a] = (winner == 1) ? rv.l_wdata : rv.c_wdata;
            else
                ref_rd[winner] = ref_mem[a];
            rv.exp_grant = (winner == 1) ? 2'b10 : 2'b01;
            rv.exp_crd   = ref_rd[0];
            rv.exp_lrd   = ref_rd[1];
            run_vec(rv, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
